// File: rtl/uart_cmd_engine.sv
// Serial command engine: assembles 5-byte frames from uart_rx, runs them against hyper_xface, returns one 4-byte word.
// Latency: EXEC one cycle after the 5th byte; first tx_start two cycles later when tx_ready is high (plus memory time).
// Backpressure: paced by tx_ready and hr_busy; bytes arriving outside COLLECT are dropped and flagged (rx_overrun).
// Optional feature: define FRAME_TIMEOUT_EN to discard partial frames after FRAME_TIMEOUT idle cycles.
module uart_cmd_engine #(
    parameter int unsigned MEM_TIMEOUT = 4096,
    parameter logic [31:0] CONST_WORD  = 32'h00000103
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int unsigned FRAME_TIMEOUT = 24000000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_rcv,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [31:0] hr_addr,
    output logic [31:0] hr_wr_d,
    output logic        hr_wr_req,
    output logic        hr_rd_req,
    input  logic        hr_busy,
    input  logic        hr_rd_rdy,
    input  logic [31:0] hr_rd_d,
    output logic        rx_overrun,
    output logic        mem_timeout
);

    localparam logic [7:0] CMD_ADDR     = 8'd1;
    localparam logic [7:0] CMD_LOAD     = 8'd2;
    localparam logic [7:0] CMD_WRITE    = 8'd3;
    localparam logic [7:0] CMD_READ     = 8'd4;
    localparam logic [7:0] CMD_READ_REQ = 8'd5;
    localparam logic [7:0] CMD_COUNT    = 8'd6;
    localparam logic [7:0] CMD_CONST    = 8'd7;

    localparam int unsigned    TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_TX_SEND,
        S_TX_WAIT_LO,
        S_TX_WAIT_HI
    } state_t;

    state_t             state_q, state_d;
    logic [39:0]        frame_q, frame_d;
    // Counts received bytes in COLLECT and remaining response bytes while transmitting.
    logic [2:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]        op_cnt_q, op_cnt_d;
    logic [31:0]        rd_latch_q, rd_latch_d;
    logic [31:0]        resp_q, resp_d;
    logic [31:0]        hr_addr_q, hr_addr_d;
    logic [31:0]        hr_wr_d_q, hr_wr_d_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_req_q, rd_req_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               seen_busy_q, seen_busy_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               rx_overrun_q, rx_overrun_d;
    logic               mem_timeout_q, mem_timeout_d;

    logic [7:0]         cmd;
    logic [31:0]        data;
    logic               mem_done;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned       IDLE_W    = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRAME_TIMEOUT - 1);
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
`endif

    assign cmd  = frame_q[39:32];
    assign data = frame_q[31:0];

    // Memory completion: writes finish once busy has been seen and dropped, reads on the data strobe.
    always_comb begin
        mem_done = 1'b0;
        if (cmd == CMD_WRITE) begin
            mem_done = seen_busy_q && !hr_busy;
        end else begin
            mem_done = hr_rd_rdy;
        end
    end

    // Next-state and datapath updates for the frame/execute/transmit sequence.
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        byte_cnt_d    = byte_cnt_q;
        op_cnt_d      = op_cnt_q;
        rd_latch_d    = rd_latch_q;
        resp_d        = resp_q;
        hr_addr_d     = hr_addr_q;
        hr_wr_d_d     = hr_wr_d_q;
        wr_req_d      = 1'b0;
        rd_req_d      = 1'b0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        seen_busy_d   = seen_busy_q;
        tmo_cnt_d     = tmo_cnt_q;
        rx_overrun_d  = rx_overrun_q;
        mem_timeout_d = mem_timeout_q;
`ifdef FRAME_TIMEOUT_EN
        idle_cnt_d    = '0;
`endif

        if (rx_rcv && (state_q != S_COLLECT)) begin
            rx_overrun_d = 1'b1;
        end

        case (state_q)
            S_COLLECT: begin
                if (rx_rcv) begin
                    frame_d = {frame_q[31:0], rx_data};
                    if (byte_cnt_q == 3'd4) begin
                        byte_cnt_d = 3'd0;
                        state_d    = S_EXEC;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                // A stalled partial frame is dropped so the next full frame realigns.
                else if (byte_cnt_q != 3'd0) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        byte_cnt_d = 3'd0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end

            S_EXEC: begin
                byte_cnt_d  = 3'd4;
                tmo_cnt_d   = '0;
                seen_busy_d = 1'b0;
                state_d     = S_TX_SEND;
                case (cmd)
                    CMD_ADDR: begin
                        hr_addr_d = data;
                        resp_d    = data;
                    end
                    CMD_LOAD: begin
                        hr_wr_d_d = data;
                        resp_d    = data;
                    end
                    CMD_COUNT: begin
                        resp_d   = op_cnt_q;
                        op_cnt_d = op_cnt_q + 32'd1;
                    end
                    CMD_CONST:    resp_d  = CONST_WORD;
                    CMD_READ:     resp_d  = rd_latch_q;
                    CMD_WRITE:    state_d = S_MEM_REQ;
                    CMD_READ_REQ: state_d = S_MEM_REQ;
                    default:      resp_d  = op_cnt_q;
                endcase
            end

            S_MEM_REQ: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_cnt_q == TMO_LAST) begin
                    resp_d        = 32'hDEADDEAD;
                    mem_timeout_d = 1'b1;
                    state_d       = S_TX_SEND;
                end else if (!hr_busy) begin
                    wr_req_d = (cmd == CMD_WRITE);
                    rd_req_d = (cmd != CMD_WRITE);
                    state_d  = S_MEM_WAIT;
                end
            end

            S_MEM_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (hr_busy) begin
                    seen_busy_d = 1'b1;
                end
                // Completion is checked first so a read landing on the expiry cycle still succeeds.
                if (mem_done) begin
                    if (cmd == CMD_WRITE) begin
                        resp_d = 32'h3;
                    end else begin
                        resp_d     = 32'h5;
                        rd_latch_d = hr_rd_d;
                    end
                    state_d = S_TX_SEND;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    resp_d        = 32'hDEADDEAD;
                    mem_timeout_d = 1'b1;
                    state_d       = S_TX_SEND;
                end
            end

            S_TX_SEND: begin
                if (tx_ready) begin
                    tx_data_d  = resp_q[31:24];
                    tx_start_d = 1'b1;
                    state_d    = S_TX_WAIT_LO;
                end
            end

            // uart_tx needs a couple of cycles to drop ready; waiting for low prevents a double start.
            S_TX_WAIT_LO: begin
                if (!tx_ready) begin
                    state_d = S_TX_WAIT_HI;
                end
            end

            S_TX_WAIT_HI: begin
                if (tx_ready) begin
                    resp_d     = {resp_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q - 3'd1;
                    state_d    = (byte_cnt_q == 3'd1) ? S_COLLECT : S_TX_SEND;
                end
            end

            default: state_d = S_COLLECT;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_COLLECT;
            frame_q       <= '0;
            byte_cnt_q    <= '0;
            op_cnt_q      <= '0;
            rd_latch_q    <= '0;
            resp_q        <= '0;
            hr_addr_q     <= '0;
            hr_wr_d_q     <= '0;
            wr_req_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            seen_busy_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            rx_overrun_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            byte_cnt_q    <= byte_cnt_d;
            op_cnt_q      <= op_cnt_d;
            rd_latch_q    <= rd_latch_d;
            resp_q        <= resp_d;
            hr_addr_q     <= hr_addr_d;
            hr_wr_d_q     <= hr_wr_d_d;
            wr_req_q      <= wr_req_d;
            rd_req_q      <= rd_req_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            seen_busy_q   <= seen_busy_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rx_overrun_q  <= rx_overrun_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    // Idle cycle counter for partial-frame discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign hr_addr     = hr_addr_q;
    assign hr_wr_d     = hr_wr_d_q;
    assign hr_wr_req   = wr_req_q;
    assign hr_rd_req   = rd_req_q;
    assign rx_overrun  = rx_overrun_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Randomized bench for uart_cmd_engine with a frame-level reference model.
// Models uart_tx pacing and a HyperRAM-like busy/read-strobe responder.
// Each frame's 4-byte response, request pulse counts and sticky flags are compared.
module tb_uart_cmd_engine;

    localparam logic [31:0] CONST_W = 32'h00000103;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_rcv;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [31:0] hr_addr;
    logic [31:0] hr_wr_d;
    logic        hr_wr_req;
    logic        hr_rd_req;
    logic        hr_busy;
    logic        hr_rd_rdy;
    logic [31:0] hr_rd_d;
    logic        rx_overrun;
    logic        mem_timeout;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_addr, m_wd, m_cnt, m_latch;
    int          exp_wr, exp_rd;
    logic        exp_ovr, exp_mto;

    // responder controls / observations
    logic [31:0] rd_next;
    bit          rd_tmo_mode;
    int          wr_busy_len;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [7:0]  txq[$];

    always #5 clk = ~clk;

    uart_cmd_engine #(
        .MEM_TIMEOUT(64),
        .CONST_WORD (CONST_W)
`ifdef FRAME_TIMEOUT_EN
        ,
        .FRAME_TIMEOUT(100)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_rcv     (rx_rcv),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .hr_addr    (hr_addr),
        .hr_wr_d    (hr_wr_d),
        .hr_wr_req  (hr_wr_req),
        .hr_rd_req  (hr_rd_req),
        .hr_busy    (hr_busy),
        .hr_rd_rdy  (hr_rd_rdy),
        .hr_rd_d    (hr_rd_d),
        .rx_overrun (rx_overrun),
        .mem_timeout(mem_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hr_wr_req) wr_pulses++;
        if (hr_rd_req) rd_pulses++;
    end

    // uart_tx model: capture byte, drop ready 1-2 cycles later, hold low a few cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tx_start) begin
                int d, n;
                txq.push_back(tx_data);
                d = $urandom_range(0, 1);
                repeat (d) begin
                    @(posedge clk); #1;
                    check_eq("tx_restart", {31'd0, tx_start}, 32'd0);
                end
                tx_ready = 1'b0;
                n = $urandom_range(3, 8);
                repeat (n) begin
                    @(posedge clk); #1;
                    check_eq("tx_restart", {31'd0, tx_start}, 32'd0);
                end
                tx_ready = 1'b1;
            end
        end
    end

    // Memory responder.
    initial begin
        hr_busy   = 1'b0;
        hr_rd_rdy = 1'b0;
        hr_rd_d   = '0;
        forever begin
            @(posedge clk); #1;
            if (hr_wr_req) begin
                int n;
                check_eq("wr_addr", hr_addr, m_addr);
                check_eq("wr_data", hr_wr_d, m_wd);
                n = (wr_busy_len != 0) ? wr_busy_len : $urandom_range(1, 12);
                hr_busy = 1'b1;
                repeat (n) @(posedge clk);
                #1 hr_busy = 1'b0;
            end else if (hr_rd_req && !rd_tmo_mode) begin
                int k;
                k = $urandom_range(0, 4);
                if (k > 0) begin
                    hr_busy = 1'b1;
                    repeat (k) @(posedge clk);
                    #1;
                end
                hr_busy   = 1'b0;
                hr_rd_rdy = 1'b1;
                hr_rd_d   = rd_next;
                @(posedge clk); #1;
                hr_rd_rdy = 1'b0;
                hr_rd_d   = $urandom;
            end
        end
    end

    task automatic model_reset();
        m_addr = '0; m_wd = '0; m_cnt = '0; m_latch = '0;
        exp_ovr = 1'b0; exp_mto = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 3);
        repeat (gap) @(posedge clk);
        #1 rx_rcv = 1'b1; rx_data = b;
        @(posedge clk);
        #1 rx_rcv = 1'b0; rx_data = $urandom;
    endtask

    task automatic wait_tx_byte(output logic [7:0] b);
        int t;
        t = 0;
        while (txq.size() == 0 && t < 600) begin
            @(posedge clk); #1;
            t++;
        end
        if (txq.size() == 0) begin
            check_eq("tx_byte_wait_expired", 32'd1, 32'd0);
            b = 8'h00;
        end else begin
            b = txq.pop_front();
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] d, input bit inject);
        logic [31:0] exp, got;
        logic [7:0]  b;
        int          t;
        case (cmd)
            8'd1: begin m_addr = d; exp = d; end
            8'd2: begin m_wd = d; exp = d; end
            8'd3: begin exp_wr++; exp = 32'h3; end
            8'd4: exp = m_latch;
            8'd5: begin
                exp_rd++;
                if (rd_tmo_mode) begin exp = 32'hDEADDEAD; exp_mto = 1'b1; end
                else begin m_latch = rd_next; exp = 32'h5; end
            end
            8'd6: begin exp = m_cnt; m_cnt = m_cnt + 1; end
            8'd7: exp = CONST_W;
            default: exp = m_cnt;
        endcase
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        got = '0;
        for (int i = 0; i < 4; i++) begin
            wait_tx_byte(b);
            got = {got[23:0], b};
            if (inject && i == 0) begin
                t = 0;
                while (tx_ready && t < 50) begin @(posedge clk); #1; t++; end
                @(posedge clk); #1;
                rx_rcv = 1'b1; rx_data = 8'hAA;
                @(posedge clk); #1;
                rx_rcv = 1'b0;
                exp_ovr = 1'b1;
            end
        end
        check_eq($sformatf("resp_cmd%0h", cmd), got, exp);
        repeat (20) @(posedge clk);
        #1;
        check_eq("tx_extra_bytes", txq.size(), 32'd0);
        check_eq("wr_pulses", wr_pulses, exp_wr);
        check_eq("rd_pulses", rd_pulses, exp_rd);
        check_eq("rx_overrun", {31'd0, rx_overrun}, {31'd0, exp_ovr});
        check_eq("mem_timeout", {31'd0, mem_timeout}, {31'd0, exp_mto});
        check_eq("hr_addr", hr_addr, m_addr);
        check_eq("hr_wr_d", hr_wr_d, m_wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check_eq({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check_eq({tag, "_hr_addr"}, hr_addr, 32'd0);
        check_eq({tag, "_hr_wr_d"}, hr_wr_d, 32'd0);
        check_eq({tag, "_reqs"}, {30'd0, hr_wr_req, hr_rd_req}, 32'd0);
        check_eq({tag, "_flags"}, {30'd0, rx_overrun, mem_timeout}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] cmd;
        int         t;
        reset = 1'b1; rx_rcv = 1'b0; rx_data = '0;
        rd_next = '0; rd_tmo_mode = 1'b0; wr_busy_len = 0;
        exp_wr = 0; exp_rd = 0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 check_reset_outputs("reset");
        reset = 1'b0;

        // directed sequence
        run_frame(8'd1, 32'h00000010, 1'b0);
        run_frame(8'd2, 32'hCAFEBABE, 1'b0);
        wr_busy_len = 20;
        run_frame(8'd3, 32'h00000000, 1'b0);
        wr_busy_len = 0;
        rd_next = 32'h12345678;
        run_frame(8'd5, 32'h00000000, 1'b0);
        run_frame(8'd4, 32'h00000000, 1'b0);
        run_frame(8'd6, 32'h0, 1'b0);
        run_frame(8'd6, 32'h0, 1'b0);
        run_frame(8'd6, 32'h0, 1'b0);
        run_frame(8'd7, 32'h0, 1'b0);
        run_frame(8'd9, 32'h0, 1'b0);
        run_frame(8'd6, 32'h0, 1'b0);
        rd_tmo_mode = 1'b1;
        run_frame(8'd5, 32'h0, 1'b0);
        rd_tmo_mode = 1'b0;
        run_frame(8'd7, 32'h0, 1'b0);
        run_frame(8'd4, 32'h0, 1'b0);
        run_frame(8'd6, 32'h0, 1'b1);

`ifdef FRAME_TIMEOUT_EN
        send_byte(8'd1);
        send_byte(8'h55);
        repeat (150) @(posedge clk);
        run_frame(8'd1, 32'h0BADF00D, 1'b0);
`endif

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            t = $urandom_range(0, 8);
            if (t == 8) begin
                cmd = $urandom;
                if (cmd >= 8'd1 && cmd <= 8'd7) cmd = 8'd0;
            end else begin
                cmd = 8'(t);
            end
            rd_next = $urandom;
            rd_tmo_mode = ($urandom_range(0, 9) == 0);
            run_frame(cmd, $urandom, ($urandom_range(0, 7) == 0));
        end
        rd_tmo_mode = 1'b0;

        // reset in the middle of a response
        send_byte(8'd7);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        wait_tx_byte(b);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        t = 0;
        while (!tx_ready && t < 50) begin @(posedge clk); #1; t++; end
        repeat (30) @(posedge clk);
        #1;
        check_eq("midreset_no_more_tx", txq.size(), 32'd0);
        txq.delete();
        run_frame(8'd6, 32'h0, 1'b0);
        run_frame(8'd4, 32'h0, 1'b0);
        run_frame(8'd1, 32'h89ABCDEF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
